// File: rtl/fir_sample_batcher_if.sv
// Sample-side handshake and FIR-side batch bus of the sample batcher.
// The master side feeds samples and models the FIR filter; the slave side is the batcher.
interface fir_sample_batcher_if #(
    parameter int SAMPLES_NUM  = 4,
    parameter int SAMPLE_WIDTH = 16
);
    logic signed [SAMPLE_WIDTH-1:0]          sampleIn;
    logic                                    sampleValidIn;
    logic                                    sampleReadyOut;
    logic                                    flushIn;
    logic                                    firBusyIn;
    logic                                    firStartOut;
    logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0]     firDataOut;
    logic [15:0]                             batchCountOut;

    modport master (
        output sampleIn,
        output sampleValidIn,
        output flushIn,
        output firBusyIn,
        input  sampleReadyOut,
        input  firStartOut,
        input  firDataOut,
        input  batchCountOut
    );

    modport slave (
        input  sampleIn,
        input  sampleValidIn,
        input  flushIn,
        input  firBusyIn,
        output sampleReadyOut,
        output firStartOut,
        output firDataOut,
        output batchCountOut
    );
endinterface

// File: rtl/fir_sample_batcher.sv
// Packs a sample stream into fixed-size batches and hands each batch to a FIR
// filter through a one-deep pending slot, so filling overlaps filtering.
module fir_sample_batcher #(
    parameter int SAMPLES_NUM  = 4,
    parameter int SAMPLE_WIDTH = 16
) (
    input logic                clkIn,
    input logic                resetIn,
    fir_sample_batcher_if.slave bus
);
    localparam int CW = $clog2(SAMPLES_NUM + 1);
    localparam int DW = SAMPLE_WIDTH * SAMPLES_NUM;
    localparam logic [CW-1:0] FULL = CW'(SAMPLES_NUM);

    typedef enum logic [1:0] {
        EMPTY,
        PENDING,
        WAIT_BUSY
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   fill_q, fill_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic [15:0]     batch_q, batch_d;

    logic            closed;
    logic            transfer;
    logic            ready;
    logic            start;
    logic            accept;

    always_comb begin
        closed   = (cnt_q == FULL) || (flush_q && (cnt_q != '0));
        transfer = (state_q == EMPTY) && closed;
        ready    = !resetIn && (!closed || (state_q == EMPTY));
        start    = !resetIn && (state_q == PENDING) && !bus.firBusyIn;
        accept   = bus.sampleValidIn && ready;

        state_d  = state_q;
        fill_d   = fill_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        batch_d  = batch_q;

        if (transfer) begin
            pend_d  = fill_q;
            fill_d  = '0;
            cnt_d   = '0;
            flush_d = 1'b0;
        end

        // cnt_d here is the slot count the incoming sample/flush applies to
        if (bus.flushIn && (accept || (cnt_d != '0)) && (cnt_d != FULL)) begin
            flush_d = 1'b1;
        end

        if (accept) begin
            for (int k = 0; k < SAMPLES_NUM; k++) begin
                if (cnt_d == CW'(k)) begin
                    fill_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.sampleIn;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end

        unique case (state_q)
            EMPTY: begin
                if (transfer) state_d = PENDING;
            end
            PENDING: begin
                if (start) begin
                    state_d = WAIT_BUSY;
                    batch_d = batch_q + 16'd1;
                end
            end
            WAIT_BUSY: begin
                if (bus.firBusyIn) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            batch_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            batch_q <= batch_d;
        end
    end

    assign bus.sampleReadyOut = ready;
    assign bus.firStartOut    = start;
    assign bus.firDataOut     = pend_q;
    assign bus.batchCountOut  = batch_q;
endmodule

// File: tb/tb_fir_sample_batcher.sv
// Bench for fir_sample_batcher: directed vector table, hand sequences and a
// random stream checked against a batch-level queue model.
module tb_fir_sample_batcher;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int DW = N * W;

    logic clk = 1'b0;
    logic rst;

    fir_sample_batcher_if #(.SAMPLES_NUM(N), .SAMPLE_WIDTH(W)) bus ();

    fir_sample_batcher #(.SAMPLES_NUM(N), .SAMPLE_WIDTH(W)) dut (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          r_ready;
    logic          r_start;
    logic [DW-1:0] r_data;
    logic [15:0]   r_cnt;

    // Batch-level model: accepted samples in order, grouped into batches
    logic [W-1:0]  cur[$];
    logic [DW-1:0] expq[$];
    int            issued;

    int fir_delay = 0;
    int fir_hold  = 0;

    typedef struct {
        logic          r;
        logic          v;
        logic [W-1:0]  s;
        logic          fl;
        logic          busy;
        logic          chk;
        logic          e_ready;
        logic          e_start;
        logic [DW-1:0] e_data;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_cur();
        logic [DW-1:0] b;
        b = '0;
        foreach (cur[i]) b[i*W +: W] = cur[i];
        return b;
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] s,
                         input logic fl, input logic busy, input logic r);
        @(negedge clk);
        rst               = r;
        bus.sampleValidIn = v;
        bus.sampleIn      = s;
        bus.flushIn       = fl;
        bus.firBusyIn     = busy;
        #1;
        r_ready = bus.sampleReadyOut;
        r_start = bus.firStartOut;
        r_data  = bus.firDataOut;
        r_cnt   = bus.batchCountOut;
        if (r) begin
            cur.delete();
            expq.delete();
            issued = 0;
        end else begin
            if (r_start) begin
                if (expq.size() == 0) begin
                    check("start_without_batch", DW'(r_start), '0);
                end else begin
                    check("batch_data", r_data, expq.pop_front());
                    check("batch_count", DW'(r_cnt), DW'(issued[15:0]));
                    issued++;
                end
            end
            if (v && r_ready) begin
                cur.push_back(s);
                if (cur.size() == N) begin
                    expq.push_back(pack_cur());
                    cur.delete();
                end
            end
            if (fl && cur.size() > 0) begin
                expq.push_back(pack_cur());
                cur.delete();
            end
        end
        @(posedge clk);
    endtask

    function automatic logic fir_busy();
        return (fir_delay == 0) && (fir_hold > 0);
    endfunction

    task automatic fir_step(input int dmax);
        if (fir_hold > 0) begin
            if (fir_delay > 0) fir_delay--;
            else fir_hold--;
        end
        if (r_start) begin
            fir_delay = $urandom_range(0, dmax);
            fir_hold  = $urandom_range(1, 3);
        end
    endtask

    task automatic do_reset();
        fir_delay = 0;
        fir_hold  = 0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push4(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, base + W'(i), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input int maxc, input int dmax);
        for (int i = 0; i < maxc; i++) begin
            if (expq.size() == 0 && fir_hold == 0) break;
            cycle(1'b0, '0, 1'b0, fir_busy(), 1'b0);
            fir_step(dmax);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [W-1:0] s,
                       input logic fl, input logic busy, input logic chk,
                       input logic er, input logic es,
                       input logic [DW-1:0] ed, input logic [15:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.fl = fl; t.busy = busy;
        t.chk = chk; t.e_ready = er; t.e_start = es;
        t.e_data = ed; t.e_cnt = ec;
        tbl.push_back(t);
    endtask

    initial begin
        logic [DW-1:0] b1, b2, b3;
        int idx;
        int starts;

        rst               = 1'b1;
        bus.sampleValidIn = 1'b0;
        bus.sampleIn      = '0;
        bus.flushIn       = 1'b0;
        bus.firBusyIn     = 1'b0;
        issued            = 0;

        b1 = 64'h0004_0003_0002_0001;
        b2 = 64'h0000_0000_8000_7FFF;
        b3 = 64'h0044_0033_0022_0011;

        //  r  v  s         fl busy chk rdy start data cnt
        add(1, 0, 16'h0000, 0, 0,   0,  0,  0,    '0, 0);
        add(1, 0, 16'h0000, 0, 0,   1,  0,  0,    '0, 0);
        add(0, 1, 16'h0001, 0, 0,   1,  1,  0,    '0, 0);
        add(0, 1, 16'h0002, 0, 0,   1,  1,  0,    '0, 0);
        add(0, 1, 16'h0003, 0, 0,   1,  1,  0,    '0, 0);
        add(0, 1, 16'h0004, 0, 0,   1,  1,  0,    '0, 0);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    '0, 0);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  1,    b1, 0);
        add(0, 0, 16'h0000, 0, 1,   1,  1,  0,    b1, 1);
        add(0, 1, 16'h7FFF, 0, 0,   1,  1,  0,    b1, 1);
        add(0, 1, 16'h8000, 0, 0,   1,  1,  0,    b1, 1);
        add(0, 0, 16'h0000, 1, 0,   1,  1,  0,    b1, 1);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b1, 1);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  1,    b2, 1);
        add(0, 0, 16'h0000, 0, 1,   1,  1,  0,    b2, 2);
        add(0, 0, 16'h0000, 1, 0,   1,  1,  0,    b2, 2);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 1, 16'h0011, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 1, 16'h0022, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 1, 16'h0033, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 1, 16'h0044, 1, 0,   1,  1,  0,    b2, 2);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b2, 2);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  1,    b3, 2);
        add(0, 0, 16'h0000, 0, 1,   1,  1,  0,    b3, 3);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b3, 3);
        add(0, 0, 16'h0000, 0, 0,   1,  1,  0,    b3, 3);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].fl, tbl[i].busy, tbl[i].r);
            check($sformatf("vec%0d_ready", i), DW'(r_ready), DW'(tbl[i].e_ready));
            check($sformatf("vec%0d_start", i), DW'(r_start), DW'(tbl[i].e_start));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_data", i), r_data, tbl[i].e_data);
                check($sformatf("vec%0d_cnt", i), DW'(r_cnt), DW'(tbl[i].e_cnt));
            end
        end

        // Downstream busy: two batches buffered, then back-pressure
        do_reset();
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(idx < 12, 16'h0100 + W'(idx), 1'b0, 1'b1, 1'b0);
            if (idx < 12 && r_ready) idx++;
        end
        check("busy_accepts", DW'(idx), DW'(8));
        check("busy_ready_low", DW'(r_ready), '0);
        for (int i = 0; i < 200; i++) begin
            if (issued >= 3 && expq.size() == 0) break;
            cycle(idx < 12, 16'h0100 + W'(idx), 1'b0, fir_busy(), 1'b0);
            if (idx < 12 && r_ready) idx++;
            fir_step(2);
        end
        check("busy_batches", DW'(issued), DW'(3));
        check("busy_all_taken", DW'(idx), DW'(12));

        // Busy rises the cycle after start: exactly one pulse
        do_reset();
        push4(16'h0200);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0, fir_busy(), 1'b0);
            if (r_start) starts++;
            fir_step(0);
        end
        check("one_start_per_batch", DW'(starts), DW'(1));

        // Reset while waiting for busy
        do_reset();
        push4(16'h0300);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (r_start) break;
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("wait_start_low", DW'(r_start), '0);
        cycle(1'b1, 16'h0399, 1'b0, 1'b0, 1'b1);
        check("rst_ready_low", DW'(r_ready), '0);
        check("rst_start_low", DW'(r_start), '0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("post_rst_ready", DW'(r_ready), DW'(1));
        check("post_rst_data", r_data, '0);
        check("post_rst_cnt", DW'(r_cnt), '0);
        push4(16'h0400);
        drain(40, 1);
        check("post_rst_batches", DW'(issued), DW'(1));

        // Reset with a partial batch buffered
        cycle(1'b1, 16'h0501, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0502, 1'b0, 1'b0, 1'b0);
        fir_delay = 0;
        fir_hold  = 0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        push4(16'h0600);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("partial_rst_ready", DW'(r_ready), DW'(1));
        drain(40, 1);
        check("partial_rst_batches", DW'(issued), DW'(1));

        // Random stream against the queue model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 16) == 0,
                  fir_busy(), 1'b0);
            fir_step(2);
        end
        cycle(1'b0, '0, 1'b1, fir_busy(), 1'b0);
        fir_step(2);
        drain(300, 2);
        check("drain_expq_empty", DW'(expq.size()), '0);
        check("drain_cur_empty", DW'(cur.size()), '0);
        check("drain_count", DW'(r_cnt), DW'(issued[15:0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_sample_batcher.md
FIR_SAMPLE_BATCHER -- requirements
Module: fir_sample_batcher

Interface
REQ-001 SHALL have parameter SAMPLES_NUM, default 4, samples per batch; legal range 1..8.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, bits per input sample.
REQ-003 SHALL have port clkIn  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetIn  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sampleIn  input  SAMPLE_WIDTH  signed input sample.
REQ-006 SHALL have port sampleValidIn  input  1  sampleIn is valid.
REQ-007 SHALL have port sampleReadyOut  output  1  the block can accept a sample.
REQ-008 SHALL have port flushIn  input  1  close the partial batch and zero-pad it.
REQ-009 SHALL have port firBusyIn  input  1  busy flag from the downstream FIR filter.
REQ-010 SHALL have port firStartOut  output  1  start strobe to the FIR filter.
REQ-011 SHALL have port firDataOut  output  SAMPLE_WIDTH*SAMPLES_NUM  batch presented to the FIR filter.
REQ-012 SHALL have port batchCountOut  output  16  number of batches issued, wrapping modulo 2^16.

Function
REQ-013 SHALL transfer a sample on each clkIn edge where sampleValidIn and sampleReadyOut are both 1.
REQ-014 SHALL write the k-th accepted sample of a batch (k = 0..SAMPLES_NUM-1) to fill-register bits [SAMPLE_WIDTH*(k+1)-1 : SAMPLE_WIDTH*k], with fill count fillCnt = k+1 after the write.
REQ-015 SHALL implement a pending-slot FSM with states EMPTY, PENDING and WAIT_BUSY; the reset state is EMPTY.
REQ-016 SHALL treat the fill register as closed when fillCnt == SAMPLES_NUM, or when a flush is latched and fillCnt > 0.
REQ-017 SHALL, in EMPTY with the fill register closed, copy the fill register to the pending register, set fillCnt = 0, clear the fill register and the flush latch, and enter PENDING, all on one edge.
REQ-018 SHALL drive firStartOut = (state == PENDING) && !firBusyIn combinationally.
REQ-019 SHALL drive firDataOut from the pending register at all times.
REQ-020 SHALL, on an edge where firStartOut = 1, enter WAIT_BUSY and increment batchCountOut.
REQ-021 SHALL leave WAIT_BUSY for EMPTY on the first edge where firBusyIn = 1, and SHALL keep firStartOut = 0 while in WAIT_BUSY.
REQ-022 SHALL keep the pending register unchanged while the state is PENDING or WAIT_BUSY.
REQ-023 SHALL drive sampleReadyOut = !closed || (state == EMPTY), combinationally.
REQ-024 SHALL, when an accepted sample coincides with the REQ-017 transfer, write that sample to slot 0 of the cleared fill register and set fillCnt = 1; this gives one sample per clock sustained throughput.
REQ-025 SHALL fill slots that were never written in a flushed batch with zeros.
REQ-026 SHALL, on flushIn with fillCnt == 0 and no sample accepted that cycle, do nothing.
REQ-027 SHALL, on flushIn in the same cycle as an accepted sample, include that sample in the flushed batch.
REQ-028 SHALL, on flushIn when fillCnt == SAMPLES_NUM, have no extra effect.
REQ-029 SHALL hold a latched flush until the REQ-017 transfer that consumes it.
REQ-030 SHALL keep batchCountOut incrementing by exactly 1 per issued batch, wrapping from 0xFFFF to 0x0000.

Reset
REQ-031 SHALL, on an edge with resetIn = 1, set state = EMPTY, fillCnt = 0, the fill and pending registers = 0, the flush latch = 0 and batchCountOut = 0.
REQ-032 SHALL force sampleReadyOut = 0 and firStartOut = 0 while resetIn = 1.
REQ-033 SHALL discard any partial or pending batch on a reset mid-operation, including in WAIT_BUSY; after the reset, sampleReadyOut = 1 in the first cycle with resetIn = 0.

Verification
REQ-034 SHALL be verified by: SAMPLES_NUM=4, firBusyIn=0, stream 1,2,3,4 back-to-back -> one firStartOut pulse with firDataOut = 0x0004_0003_0002_0001 and batchCountOut = 1.
REQ-035 SHALL be verified by: firBusyIn held 1 while 12 samples are offered continuously -> 8 samples accepted, then sampleReadyOut = 0; after firBusyIn falls, the next batch issues with no sample lost or reordered.
REQ-036 SHALL be verified by: samples 0x7FFF and 0x8000, then flushIn -> batch = 0x0000_0000_8000_7FFF.
REQ-037 SHALL be verified by: flushIn with fillCnt = 0 -> no firStartOut pulse and batchCountOut unchanged; flushIn together with the 4th sample -> exactly one batch issued.
REQ-038 SHALL be verified by: firBusyIn rises one cycle after firStartOut -> exactly one start pulse per batch, and no second pulse during the WAIT_BUSY cycle.
REQ-039 SHALL be verified by: resetIn asserted in WAIT_BUSY and after 2 samples are buffered -> all outputs at reset values, and the next 4 samples form a fresh batch.
